pid_mul_scheduler: RTL

Round-robin scheduler that time-shares one sequential shift-add multiplier among the three PID gain stages: proportional, integral and derivative. Each stage requests a coefficient-times-operand product, so only one multiplier exists in silicon. The block arbitrates, captures operands, sequences the six multiply iterations and returns the product with a per-requester done pulse. It sits between the P/I/D term blocks and the output summer.

---
 rtl/pid_mul_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pid_mul_scheduler.sv
// Round-robin arbiter sharing one 6x6 sequential shift-add multiplier among the
// P, I and D gain stages; returns a 12-bit product with a per-requester done pulse.
module pid_mul_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [2:0]  req,
    input  logic [17:0] op_a,
    input  logic [17:0] op_b,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [2:0]  done,
    output logic [11:0] product
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  win_q, win_d;
    logic [2:0]  grant_q, grant_d;
    logic [5:0]  a_q, a_d;
    logic [5:0]  b_q, b_d;
    logic [11:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] product_q, product_d;
    logic [2:0]  done_q, done_d;
    logic        busy_q, busy_d;

    logic [1:0]  pick_s;
    logic [7:0]  b_ext_s;
    logic [11:0] step_s;

    // Search starts just after the last winner, wrapping 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        idx     = l;
        for (int i = 0; i < 3; i++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [5:0] lane(input logic [17:0] v, input logic [1:0] i);
        case (i)
            2'd0:    lane = v[5:0];
            2'd1:    lane = v[11:6];
            default: lane = v[17:12];
        endcase
    endfunction

    // Next-state, datapath and output register computation.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_d     = win_q;
        grant_d   = grant_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = done_q;

        pick_s  = rr_pick(req, last_q);
        b_ext_s = {2'b00, b_q};
        if (b_ext_s[cnt_q]) begin
            step_s = acc_q + ({6'd0, a_q} << cnt_q);
        end else begin
            step_s = acc_q;
        end

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (req != 3'b000) begin
                        state_d = ST_BUSY;
                        win_d   = pick_s;
                        grant_d = 3'b001 << pick_s;
                        a_d     = lane(op_a, pick_s);
                        b_d     = lane(op_b, pick_s);
                        acc_d   = 12'd0;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_d = step_s;
                    if (cnt_q == 3'd5) begin
                        state_d   = ST_DONE;
                        product_d = step_s;
                        done_d    = grant_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                    done_d  = 3'b000;
                    last_d  = win_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                    done_d  = 3'b000;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset; last starts at D so P wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'd2;
            win_q     <= 2'd0;
            grant_q   <= 3'b000;
            a_q       <= 6'd0;
            b_q       <= 6'd0;
            acc_q     <= 12'd0;
            cnt_q     <= 3'd0;
            product_q <= 12'd0;
            done_q    <= 3'b000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
